// File: rtl/sdu_uart_rx_if.sv
// sdu_uart_rx_if
//   Byte stream from the UART receive FIFO to the SDU command parser.
//   dout     : byte at the FIFO head, meaningful only while dout_vld=1
//   dout_vld : FIFO is non-empty
//   dout_rdy : consumer accepts dout this cycle
//   master = receiver side, slave = consumer side.
interface sdu_uart_rx_if;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_rdy;

    modport master (output dout, output dout_vld, input dout_rdy);
    modport slave  (input dout, input dout_vld, output dout_rdy);
endinterface

// File: rtl/sdu_uart_rx.sv
// sdu_uart_rx
//   8N1 UART receive front end for the serial debug unit. Synchronizes rxd,
//   recovers frames with a mid-bit sampling FSM, buffers bytes in a
//   first-word-fall-through FIFO and reports sticky framing/overflow errors.
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous reset, active-high
//   rxd       : asynchronous UART line, idles at 1
//   rx_if     : byte stream out (dout / dout_vld / dout_rdy), master side
//   busy      : receiver FSM not in IDLE (registered)
//   frame_err : sticky, a stop bit was sampled as 0
//   overflow  : sticky, a completed byte was dropped on a full FIFO
//   err_clr   : pulse clearing both sticky flags (a same-cycle error wins)
module sdu_uart_rx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    sdu_uart_rx_if.master     rx_if,
    output logic              busy,
    output logic              frame_err,
    output logic              overflow,
    input  logic              err_clr
);

    localparam int DIV    = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int HALF   = DIV / 2;
    localparam int CNT_W  = $clog2(DIV + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int OCC_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state, state_nxt;
    logic               rx_s1, rxs;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;
    logic               bit_done, half_done;
    logic               shift_en, push, ferr_set;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [OCC_W-1:0]   count;
    logic [7:0]         dout_q;
    logic               pop, push_ok;

    // Two-flop synchronizer; both stages reset to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rxs   <= rx_s1;
        end
    end

    assign bit_done  = (cnt == CNT_W'(DIV - 1));
    assign half_done = (cnt == CNT_W'(HALF - 1));

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // FSM: next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!rxs) state_nxt = S_START;
            S_START: if (half_done) state_nxt = rxs ? S_IDLE : S_DATA;
            S_DATA:  if (bit_done && bit_idx == 3'd7) state_nxt = S_STOP;
            S_STOP:  if (bit_done) state_nxt = rxs ? S_IDLE : S_BREAK;
            S_BREAK: if (rxs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        shift_en = 1'b0;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state)
            S_DATA:  shift_en = bit_done;
            S_STOP: begin
                push     = bit_done && rxs;
                ferr_set = bit_done && !rxs;
            end
            default: ;
        endcase
    end

    // Bit timing and shift register. The counter restarts on every state
    // entry and wraps each bit period so DATA samples every DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            busy    <= 1'b0;
        end else begin
            if (state_nxt != state || bit_done) cnt <= '0;
            else                                cnt <= cnt + CNT_W'(1);

            if (state == S_START)  bit_idx <= '0;
            else if (shift_en)     bit_idx <= bit_idx + 3'd1;

            if (shift_en) shreg <= {rxs, shreg[7:1]};

            busy <= (state != S_IDLE);
        end
    end

    // FIFO
    assign pop        = rx_if.dout_vld && rx_if.dout_rdy;
    assign push_ok    = push && ((count < OCC_W'(FIFO_DEPTH)) || pop);
    assign rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dout_q    <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_ptr_nxt;

            case ({push_ok, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: ;
            endcase

            // Registered head: a byte written into the slot that becomes the
            // head bypasses the array so an empty FIFO shows it next cycle.
            if (push_ok && wr_ptr == rd_ptr_nxt) dout_q <= shreg;
            else if (pop)                        dout_q <= mem[rd_ptr_nxt];

            if (ferr_set)     frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;

            if (push && !push_ok) overflow <= 1'b1;
            else if (err_clr)     overflow <= 1'b0;
        end
    end

    assign rx_if.dout     = dout_q;
    assign rx_if.dout_vld = (count != '0);

endmodule

// File: tb/tb_sdu_uart_rx.sv
// tb_sdu_uart_rx
//   Directed bench for sdu_uart_rx at DIV=10, HALF=5. Expected bytes are
//   queued when a frame is sent; a negedge monitor pops and compares every
//   accepted byte.
module tb_sdu_uart_rx;

    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    logic busy, frame_err, overflow, err_clr;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic [7:0] exp_q [$];

    sdu_uart_rx_if u_if ();

    sdu_uart_rx #(
        .CLK_FREQ   (1000000),
        .BAUD       (100000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_if     (u_if.master),
        .busy      (busy),
        .frame_err (frame_err),
        .overflow  (overflow),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame, DIV cycles per bit; rxd is left at the stop level.
    task automatic send_byte(input logic [7:0] b, input logic stop_v, input logic expect_push);
        if (expect_push) exp_q.push_back(b);
        rxd = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(DIV);
        end
        rxd = stop_v;
        tick(DIV);
    endtask

    task automatic drain(input int n);
        u_if.dout_rdy = 1'b1;
        tick(n);
        u_if.dout_rdy = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && u_if.dout_vld && u_if.dout_rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {24'h0, u_if.dout}, 32'hFFFF_FFFF);
            end else begin
                chk("dout", {24'h0, u_if.dout}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int lat;

        rst = 1'b1;
        rxd = 1'b1;
        err_clr = 1'b0;
        u_if.dout_rdy = 1'b0;
        tick(5);
        rst = 1'b0;
        chk("rst_dout", u_if.dout, 0);
        chk("rst_vld", u_if.dout_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovf", overflow, 0);
        tick(20);

        // 1: single byte, latency from rxd fall to dout_vld
        u_if.dout_rdy = 1'b1;
        t0 = cyc;
        fork
            send_byte(8'h55, 1'b1, 1'b1);
            begin
                lat = -1;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (u_if.dout_vld) begin
                        lat = cyc - t0;
                        break;
                    end
                end
                chk("t1_latency", lat, 98);
                @(negedge clk);
                chk("t1_vld_pulse", u_if.dout_vld, 0);
            end
        join
        chk("t1_ferr", frame_err, 0);
        tick(20);

        // 2: glitch shorter than half a bit
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(2);
        chk("t2_busy_hi", busy, 1);
        tick(20);
        chk("t2_busy_lo", busy, 0);
        chk("t2_vld", u_if.dout_vld, 0);
        chk("t2_ferr", frame_err, 0);
        chk("t2_ovf", overflow, 0);

        // 3: framing error, held-low line, recovery, clear
        send_byte(8'hA3, 1'b0, 1'b0);
        tick(30);
        chk("t3_ferr", frame_err, 1);
        chk("t3_busy_break", busy, 1);
        chk("t3_vld", u_if.dout_vld, 0);
        rxd = 1'b1;
        tick(5);
        chk("t3_busy_idle", busy, 0);
        tick(DIV);
        send_byte(8'h3C, 1'b1, 1'b1);
        tick(5);
        chk("t3_ferr_sticky", frame_err, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t3_ferr_clr", frame_err, 0);
        chk("t3_q_empty", exp_q.size(), 0);

        // 4: overflow with consumer stalled
        u_if.dout_rdy = 1'b0;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1, 1'b1);
        chk("t4_ovf_before", overflow, 0);
        chk("t4_vld_full", u_if.dout_vld, 1);
        send_byte(8'h09, 1'b1, 1'b0);
        tick(2);
        chk("t4_ovf", overflow, 1);
        chk("t4_head", u_if.dout, 8'h01);
        drain(12);
        chk("t4_drained", exp_q.size(), 0);
        chk("t4_vld_empty", u_if.dout_vld, 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t4_ovf_clr", overflow, 0);

        // 5: push and pop in the same cycle at full
        for (int i = 0; i < 8; i++) send_byte(8'hB0 + 8'(i), 1'b1, 1'b1);
        fork
            send_byte(8'h10, 1'b1, 1'b1);
            begin
                tick(97);
                u_if.dout_rdy = 1'b1;
                tick(1);
                u_if.dout_rdy = 1'b0;
            end
        join
        tick(2);
        chk("t5_ovf", overflow, 0);
        chk("t5_head", u_if.dout, 8'hB1);
        chk("t5_q_len", exp_q.size(), 8);
        drain(12);
        chk("t5_drained", exp_q.size(), 0);
        chk("t5_vld_empty", u_if.dout_vld, 0);

        // 6: reset during data bit 4
        u_if.dout_rdy = 1'b1;
        fork
            send_byte(8'hF0, 1'b1, 1'b0);
            begin
                tick(55);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                chk("t6_dout", u_if.dout, 0);
                chk("t6_vld", u_if.dout_vld, 0);
                chk("t6_busy", busy, 0);
                chk("t6_ferr", frame_err, 0);
                chk("t6_ovf", overflow, 0);
            end
        join
        tick(20);
        chk("t6_no_partial", u_if.dout_vld, 0);
        send_byte(8'h5A, 1'b1, 1'b1);
        tick(5);
        chk("t6_q_empty", exp_q.size(), 0);
        chk("t6_ferr_end", frame_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sdu_uart_rx.md
# sdu_uart_rx

Serial receive front end for the serial debug unit (SDU). Recovers 8N1 UART frames from the asynchronous `rxd` pin, validates start and stop bits, and buffers received bytes in a small first-word-fall-through FIFO. The SDU command parser drains the FIFO through a valid/ready handshake. Framing and overflow conditions are reported as sticky error flags for the SDU to read and clear.

## Interface

Parameters:
- `CLK_FREQ`, default 100000000: `clk` frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
  - `DIV` = round(`CLK_FREQ`/`BAUD`), which is 868 at the defaults.
  - `HALF` = `DIV`/2 (integer division).
- `FIFO_DEPTH`, default 8: byte capacity of the FIFO. Must be a power of two and at least 2.

Ports:
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `rxd` input 1: asynchronous UART line. Idle level is 1.
- `dout` output 8: byte at the FIFO head. Meaningful only while `dout_vld`=1.
- `dout_vld` output 1: FIFO is non-empty.
- `dout_rdy` input 1: consumer accepts `dout` this cycle.
- `busy` output 1: the receiver FSM is not in IDLE.
- `frame_err` output 1: sticky. A stop bit was sampled as 0.
- `overflow` output 1: sticky. A completed byte was dropped because the FIFO was full.
- `err_clr` input 1: single-cycle pulse that clears both sticky flags.

## Operation

- **Input synchronizer.** `rxd` passes through a 2-flop synchronizer. Both flops reset to 1. The FSM uses only the synchronized value `rxs`.
- **Bit timing.** A bit counter counts 0..`DIV`-1 and is zeroed on every state entry.
- **FSM states and transitions:**
  - **IDLE:** on `rxs`=0, go to START.
  - **START:** when the counter reaches `HALF`-1, sample `rxs`.
    - `rxs`=0: go to DATA, with bit index 0.
    - `rxs`=1: false start. Return to IDLE with no other effect.
  - **DATA:** when the counter reaches `DIV`-1, shift `rxs` into the shift register, LSB first.
    - Bit index increments after each sample.
    - After bit index 7 is sampled, go to STOP.
  - **STOP:** when the counter reaches `DIV`-1, sample `rxs`.
    - `rxs`=1: push the byte, then go to IDLE.
    - `rxs`=0: set `frame_err`, discard the byte, go to BREAK.
  - **BREAK:** wait for `rxs`=1, then go to IDLE. This prevents a held-low line from retriggering reception.
- **FIFO.** Read and write pointers are log2(`FIFO_DEPTH`) bits wide and wrap modulo the depth. A separate occupancy count runs 0..`FIFO_DEPTH`.
  - Pop occurs when `dout_vld` && `dout_rdy`.
  - A push is accepted if count < `FIFO_DEPTH`, or if a pop occurs in the same cycle.
  - A push that is not accepted sets `overflow`. The new byte is lost; stored data is unchanged.
  - A push and a pop in the same cycle leave the count unchanged.
  - `dout_rdy` while empty is ignored.
- **Sticky flag priority.** `err_clr` in the same cycle as a new error: the error wins, and the flag stays 1.

## Timing

- **Reset values.** `dout`=0, `dout_vld`=0, `busy`=0, `frame_err`=0, `overflow`=0.
  - The FSM enters IDLE and the FIFO is emptied.
  - Reset also applies mid-frame, and any partial byte is discarded.
- **Synchronizer latency.** 2 cycles from an `rxd` edge to `rxs`.
- **Sample points.**
  - Start bit: `HALF` cycles after the falling edge is seen on `rxs`.
  - Data bit n: at `HALF`+(n+1)·`DIV` cycles after that edge.
  - Stop bit: at `HALF`+9·`DIV` cycles after that edge.
- **Push latency.** The push occurs on the stop-sample cycle. `dout_vld` rises on the following cycle, so there is 1 cycle from stop sample to visible data.
- **FIFO read behaviour.** `dout` is registered first-word-fall-through.
  - After a pop, the next entry (if any) is presented on the following cycle, with no bubble.
  - `dout_vld` stays 1 while entries remain.
- **`busy`.** Rises 1 cycle after the FSM leaves IDLE, and is 1 throughout START, DATA, STOP and BREAK.
- **Sustained throughput.** Back-to-back frames with a 1-bit stop are received with no gaps required.

## Test plan

Bench parameters: `CLK_FREQ`=1000000 and `BAUD`=100000, giving `DIV`=10 and `HALF`=5.

1. **Single byte.** Send 0x55 with `dout_rdy`=1 → `dout_vld` pulses for 1 cycle with `dout`=0x55, 98 cycles after the `rxd` fall (2 + 5 + 90 + 1). `frame_err`=0.
2. **Glitch rejection.** Drive `rxd` low for 3 cycles, then high → no push, `busy` returns to 0, no flags set.
3. **Framing error.** Send 0xA3 with the stop bit at 0, and hold `rxd` low for 30 more cycles, then high → `frame_err`=1 and the FIFO stays empty. A following 0x3C is then received correctly. `err_clr` clears `frame_err`.
4. **Overflow.** Send 9 bytes 0x01..0x09 with `dout_rdy`=0 → after 8 bytes the FIFO is full and `dout_vld`=1. Byte 0x09 sets `overflow`. Draining yields 0x01..0x08 in order.
5. **Simultaneous push and pop at full.** Fill the FIFO with 8 bytes, then assert `dout_rdy` for exactly the stop-sample cycle of byte 0x10 → the push is accepted, `overflow` stays 0, count stays 8, and the drain ends with 0x10.
6. **Reset mid-frame.** Pulse `rst` during data bit 4 of 0xF0 → all outputs return to their reset values and no partial byte appears. A subsequent 0x5A is received correctly.
